safecrack_btn_capture: RTL and testbench

Input conditioning stage placed directly upstream of the safecrack unlock FSM. It synchronises and debounces the four raw push-buttons, accumulates a chord (buttons held together), and emits the chord as a single-cycle code strobe when all buttons are released. The FSM compares `code` against its stored passcode digits, so `code` carries the chord only during the `code_valid` cycle and is `4'b0000` otherwise.

---
 rtl/safecrack_btn_capture.sv | 132 +++++++++++++
 tb/tb_safecrack_btn_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/safecrack_btn_capture.sv
// Button front end for the safecrack unlock FSM: synchronise, debounce,
// accumulate a chord and strobe it out once every button is released.
module safecrack_btn_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_HOLD        = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] code,
  output logic       code_valid,
  output logic       stuck
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      s1_q, s2_q;
  logic [3:0]      cand_q, cand_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      db_q, db_d;
  logic [3:0]      chord_q, chord_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            stuck_q, stuck_d;

  // Debouncer: the count saturates at CNT_LAST so a stable value keeps reloading btn_db.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      db_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    chord_d = chord_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (db_q != '0) begin
          chord_d = db_q;
          hold_d  = HW'(1);
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (db_q == '0) begin
          state_d = IDLE;
        end else if (hold_q == HOLD_MAX) begin
          state_d = WAIT_RELEASE;
        end else begin
          chord_d = chord_q | db_q;
          hold_d  = hold_q + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (db_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Release is tested before the timeout so a release on the timeout edge still emits.
  always_comb begin
    code_d  = '0;
    valid_d = 1'b0;
    stuck_d = 1'b0;
    case (state_q)
      PRESS: begin
        if (db_q == '0) begin
          code_d  = chord_q;
          valid_d = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          stuck_d = 1'b1;
        end
      end
      WAIT_RELEASE: stuck_d = (db_q != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      db_q    <= '0;
      state_q <= IDLE;
      chord_q <= '0;
      hold_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      state_q <= state_d;
      chord_q <= chord_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
    end
  end

  assign code       = code_q;
  assign code_valid = valid_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_safecrack_btn_capture.sv
// Bench for safecrack_btn_capture: a long-hold and a short-hold instance share
// the same stimulus and are compared every cycle against a run-length model.
module tb_safecrack_btn_capture;

  localparam int DEB   = 4;
  localparam int MAX_A = 1000;
  localparam int MAX_B = 16;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] code_a, code_b;
  logic       code_valid_a, code_valid_b;
  logic       stuck_a, stuck_b;

  safecrack_btn_capture #(.DEBOUNCE_CYCLES(DEB), .MAX_HOLD(MAX_A)) dut_a (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .code(code_a), .code_valid(code_valid_a), .stuck(stuck_a));

  safecrack_btn_capture #(.DEBOUNCE_CYCLES(DEB), .MAX_HOLD(MAX_B)) dut_b (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .code(code_b), .code_valid(code_valid_b), .stuck(stuck_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int edge_n = 0;

  // Reference model: s1/s2 pipe, debounced value = s2 once it has been seen
  // DEB+1 times in a row, then the chord rules in terms of plain flags.
  logic [3:0] m_s1[2], m_s2[2], m_last[2], m_db[2], m_chord[2], m_code[2];
  int         m_run[2], m_hold[2];
  bit         m_pressing[2], m_abandoned[2], m_valid[2], m_stuck[2];

  logic [3:0] strobes_a[$], strobes_b[$];
  int         strobe_edge_a[$];
  bit         seen_stuck_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_step(input int i, input logic [3:0] raw, input logic r);
    logic [3:0] db_old;
    int mx;
    mx = (i == 0) ? MAX_A : MAX_B;
    if (r) begin
      m_s1[i] = '0; m_s2[i] = '0; m_last[i] = '0; m_run[i] = 1; m_db[i] = '0;
      m_chord[i] = '0; m_hold[i] = 0; m_pressing[i] = 0; m_abandoned[i] = 0;
      m_code[i] = '0; m_valid[i] = 0; m_stuck[i] = 0;
      return;
    end
    db_old     = m_db[i];
    m_code[i]  = '0;
    m_valid[i] = 0;
    if (m_abandoned[i]) begin
      if (db_old == 0) begin m_abandoned[i] = 0; m_stuck[i] = 0; end
    end else if (m_pressing[i]) begin
      if (db_old == 0) begin
        m_code[i] = m_chord[i]; m_valid[i] = 1; m_pressing[i] = 0;
      end else if (m_hold[i] >= mx) begin
        m_pressing[i] = 0; m_abandoned[i] = 1; m_stuck[i] = 1;
      end else begin
        m_chord[i] = m_chord[i] | db_old; m_hold[i]++;
      end
    end else if (db_old != 0) begin
      m_chord[i] = db_old; m_hold[i] = 1; m_pressing[i] = 1;
    end
    if (m_s2[i] == m_last[i]) begin
      if (m_run[i] < 100000) m_run[i]++;
    end else begin
      m_last[i] = m_s2[i]; m_run[i] = 1;
    end
    if (m_run[i] >= DEB + 1) m_db[i] = m_last[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = raw;
  endtask

  task automatic tick(input logic [3:0] raw, input logic r);
    @(negedge clk);
    btn_raw = raw;
    rst     = r;
    @(posedge clk);
    model_step(0, raw, r);
    model_step(1, raw, r);
    #1;
    edge_n++;
    check("code_a",  {28'd0, code_a},       {28'd0, m_code[0]});
    check("valid_a", {31'd0, code_valid_a}, {31'd0, m_valid[0]});
    check("stuck_a", {31'd0, stuck_a},      {31'd0, m_stuck[0]});
    check("code_b",  {28'd0, code_b},       {28'd0, m_code[1]});
    check("valid_b", {31'd0, code_valid_b}, {31'd0, m_valid[1]});
    check("stuck_b", {31'd0, stuck_b},      {31'd0, m_stuck[1]});
    if (code_valid_a) begin strobes_a.push_back(code_a); strobe_edge_a.push_back(edge_n); end
    if (code_valid_b) strobes_b.push_back(code_b);
    if (stuck_b) seen_stuck_b = 1;
  endtask

  task automatic run(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) tick(raw, 1'b0);
  endtask

  task automatic clear_log();
    strobes_a.delete(); strobes_b.delete(); strobe_edge_a.delete();
    seen_stuck_b = 0;
  endtask

  initial begin
    int ez, ev;
    logic [3:0] seq [3];
    logic [3:0] got;
    rst = 1'b1;
    btn_raw = '0;

    for (int k = 0; k < 3; k++) tick(4'b0000, 1'b1);
    check("reset_code_a",  {28'd0, code_a}, 32'd0);
    check("reset_valid_a", {31'd0, code_valid_a}, 32'd0);
    check("reset_stuck_b", {31'd0, stuck_b}, 32'd0);
    run(4'b0000, 10);

    // Clean press; edge e samples the 0, strobe registered DEB+3 edges later.
    clear_log();
    run(4'b0111, 20);
    tick(4'b0000, 1'b0);
    ez = edge_n;
    ev = -1;
    for (int k = 0; k < 40; k++) begin
      tick(4'b0000, 1'b0);
      if (code_valid_a && ev < 0) ev = edge_n;
    end
    check("clean_count", strobes_a.size(), 32'd1);
    if (strobes_a.size() > 0) check("clean_code", {28'd0, strobes_a[0]}, 32'h7);
    check("clean_latency", ev - ez, DEB + 3);

    // Bounce rejection
    clear_log();
    for (int k = 0; k < 3; k++) begin run(4'b0001, 2); run(4'b0000, 2); end
    run(4'b0001, 10);
    run(4'b0000, 20);
    check("bounce_count", strobes_a.size(), 32'd1);
    if (strobes_a.size() > 0) check("bounce_code", {28'd0, strobes_a[0]}, 32'h1);

    // Incremental chord
    clear_log();
    run(4'b0001, 10); run(4'b0101, 10); run(4'b0100, 10); run(4'b0000, 20);
    check("incr_count", strobes_a.size(), 32'd1);
    if (strobes_a.size() > 0) check("incr_code", {28'd0, strobes_a[0]}, 32'h5);

    // Stuck button on the short-hold instance
    clear_log();
    run(4'b1000, 40);
    run(4'b0000, 20);
    check("stuck_seen_b", {31'd0, seen_stuck_b}, 32'd1);
    check("stuck_no_strobe_b", strobes_b.size(), 32'd0);
    check("stuck_cleared_b", {31'd0, stuck_b}, 32'd0);
    check("long_hold_a", strobes_a.size(), 32'd1);

    // Reset mid-chord with buttons held through it
    clear_log();
    run(4'b1101, 12);
    tick(4'b1101, 1'b1);
    check("rst_valid_a", {31'd0, code_valid_a}, 32'd0);
    check("rst_code_a",  {28'd0, code_a}, 32'd0);
    check("rst_stuck_b", {31'd0, stuck_b}, 32'd0);
    run(4'b1101, 12);
    run(4'b0000, 20);
    check("rst_count", strobes_a.size(), 32'd1);
    if (strobes_a.size() > 0) check("rst_code", {28'd0, strobes_a[0]}, 32'hD);

    // Sequence of chords into the unlock FSM
    clear_log();
    seq[0] = 4'b0111; seq[1] = 4'b1101; seq[2] = 4'b1101;
    for (int s = 0; s < 3; s++) begin run(seq[s], 8); run(4'b0000, 10); end
    run(4'b0000, 10);
    check("seq_count", strobes_a.size(), 32'd3);
    for (int s = 0; s < 3; s++) begin
      got = (s < strobes_a.size()) ? strobes_a[s] : 4'hx;
      check($sformatf("seq_code%0d", s), {28'd0, got}, {28'd0, seq[s]});
    end
    if (strobe_edge_a.size() == 3)
      check("seq_separated", {31'd0, (strobe_edge_a[1] - strobe_edge_a[0] > 1) &&
                                     (strobe_edge_a[2] - strobe_edge_a[1] > 1)}, 32'd1);

    // Random runs with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      logic [3:0] v;
      int len;
      v   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) v = 4'b0000;
      len = $urandom_range(1, 12);
      if ($urandom_range(0, 59) == 0) tick(v, 1'b1);
      run(v, len);
    end
    run(4'b0000, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
